// File: rtl/encrypt_ctrl.sv
// Byte-stream encryption controller: loads preamble length, LFSR taps and seed
// from data memory, then XOR-encrypts 64 characters into DM[64..127].
//
// state   | meaning
// IDLE    | waiting for req high (arm) then low (start)
// LD_PRE  | reading preamble length from DM[61]
// LD_TAP  | reading LFSR taps from DM[62]
// LD_SEED | reading LFSR seed from DM[63]
// RD      | reading character i-pre (or zero inside the preamble)
// WR      | writing encrypted character to DM[64+i]
// DONE    | program complete, ack held high
module encrypt_ctrl #(
  parameter bit PARITY = 1'b0
) (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  output logic [7:0] dm_addr,
  output logic       dm_we,
  output logic [7:0] dm_wdata,
  input  logic [7:0] dm_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_PRE  = 3'd1,
    LD_TAP  = 3'd2,
    LD_SEED = 3'd3,
    RD      = 3'd4,
    WR      = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t     state;
  logic       armed;
  logic [5:0] i;
  logic [6:0] lfsr;
  logic [6:0] taps;
  logic [7:0] pre;
  logic [6:0] ch;

  logic [7:0] pre_clamp;
  logic [6:0] rd_char;
  logic [6:0] enc;
  logic [6:0] lfsr_next;
  logic [5:0] i_inc;

  // Characters before the preamble end read as zero; the address is parked at 0.
  function automatic logic [7:0] rd_addr(input logic [5:0] idx, input logic [7:0] p);
    return ({2'b00, idx} >= p) ? ({2'b00, idx} - p) : 8'd0;
  endfunction

  always_comb begin
    if (dm_rdata < 8'd10)
      pre_clamp = 8'd10;
    else if (dm_rdata > 8'd26)
      pre_clamp = 8'd26;
    else
      pre_clamp = dm_rdata;
    rd_char   = ({2'b00, i} >= pre) ? dm_rdata[6:0] : 7'd0;
    enc       = ch ^ lfsr;
    lfsr_next = {lfsr[5:0], ^(lfsr & taps)};
    i_inc     = i + 6'd1;
  end

  // Write data is decoded from registered state so it is valid throughout WR.
  assign dm_wdata = (state == WR) ? {(PARITY ? ^enc : 1'b0), enc} : 8'h00;

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state   <= IDLE;
      armed   <= 1'b0;
      ack     <= 1'b0;
      dm_we   <= 1'b0;
      dm_addr <= 8'd0;
      i       <= 6'd0;
      lfsr    <= 7'd0;
      taps    <= 7'd0;
      pre     <= 8'd0;
      ch      <= 7'd0;
    end else begin
      dm_we <= 1'b0;
      case (state)
        IDLE: begin
          dm_addr <= 8'd0;
          if (req) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed   <= 1'b0;
            state   <= LD_PRE;
            dm_addr <= 8'd61;
          end
        end
        DONE: begin
          dm_addr <= 8'd0;
          if (req) begin
            state <= IDLE;
            armed <= 1'b1;
            ack   <= 1'b0;
          end
        end
        default: begin
          if (req) begin
            state   <= IDLE;
            armed   <= 1'b1;
            dm_addr <= 8'd0;
          end else begin
            case (state)
              LD_PRE: begin
                pre     <= pre_clamp;
                dm_addr <= 8'd62;
                state   <= LD_TAP;
              end
              LD_TAP: begin
                taps    <= dm_rdata[6:0];
                dm_addr <= 8'd63;
                state   <= LD_SEED;
              end
              LD_SEED: begin
                lfsr    <= (dm_rdata[6:0] == 7'd0) ? 7'd1 : dm_rdata[6:0];
                i       <= 6'd0;
                dm_addr <= rd_addr(6'd0, pre);
                state   <= RD;
              end
              RD: begin
                ch      <= rd_char;
                dm_addr <= 8'd64 + {2'b00, i};
                dm_we   <= 1'b1;
                state   <= WR;
              end
              WR: begin
                lfsr <= lfsr_next;
                if (i == 6'd63) begin
                  dm_addr <= 8'd0;
                  ack     <= 1'b1;
                  state   <= DONE;
                end else begin
                  i       <= i_inc;
                  dm_addr <= rd_addr(i_inc, pre);
                  state   <= RD;
                end
              end
              default: begin
                state   <= IDLE;
                dm_addr <= 8'd0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encrypt_ctrl.sv
// Bench for encrypt_ctrl: two instances (PARITY 0 and 1) each with its own memory,
// checked against a software encryption model of the stream.
module tb_encrypt_ctrl;

  logic       clk = 1'b0;
  logic       init = 1'b0;
  logic       req = 1'b0;
  logic       ld = 1'b0;
  logic       ack0, ack1, we0, we1;
  logic [7:0] addr0, addr1, wd0, wd1, rd0, rd1;
  logic [7:0] mem0[256];
  logic [7:0] mem1[256];
  logic [7:0] img[256];
  int         exp0[64];
  int         exp1[64];
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    int          sel;
    int          pre_raw;
    int          pre_eff;
    int          taps;
    int          seed;
    bit          fixed;
    logic [55:0] k0;
    logic [55:0] k1;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  assign rd0 = mem0[addr0];
  assign rd1 = mem1[addr1];

  encrypt_ctrl #(.PARITY(1'b0)) dut0 (
    .clk(clk), .init(init), .req(req), .ack(ack0),
    .dm_addr(addr0), .dm_we(we0), .dm_wdata(wd0), .dm_rdata(rd0)
  );

  encrypt_ctrl #(.PARITY(1'b1)) dut1 (
    .clk(clk), .init(init), .req(req), .ack(ack1),
    .dm_addr(addr1), .dm_we(we1), .dm_wdata(wd1), .dm_rdata(rd1)
  );

  always @(posedge clk) begin
    if (ld) begin
      for (int a = 0; a < 256; a++) begin
        mem0[a] <= img[a];
        mem1[a] <= img[a];
      end
    end else begin
      if (we0) mem0[addr0] <= wd0;
      if (we1) mem1[addr1] <= wd1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic set_image(input int sel, input int pre_raw, input int taps, input int seed);
    string msg;
    msg = "Mr. Watson, come here. I want to see you.";
    for (int a = 0; a < 256; a++) img[a] = (a >= 64) ? 8'hEE : 8'h00;
    if (sel == 1)
      for (int k = 0; k < msg.len(); k++) img[k] = msg[k] - 8'h20;
    else if (sel == 2)
      for (int k = 0; k < 61; k++) img[k] = 8'($urandom);
    img[61] = 8'(pre_raw);
    img[62] = 8'(taps);
    img[63] = 8'(seed);
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  // Software model: character stream delayed by pre, XORed with a 7-bit Fibonacci LFSR.
  task automatic compute_model(input int pre, input int taps, input int seed);
    int l, c, o;
    l = seed & 127;
    if (l == 0) l = 1;
    for (int k = 0; k < 64; k++) begin
      c = (k >= pre) ? int'(img[k - pre]) : 0;
      o = (c ^ l) & 127;
      exp0[k] = o;
      exp1[k] = o | ((($countones(o) % 2) == 1) ? 128 : 0);
      l = ((l << 1) & 127) | ($countones(l & taps & 127) % 2);
    end
  endtask

  // Arms with req high, starts with req low, counts edges after the start edge until ack.
  task automatic run_prog(input string nm);
    int edges;
    @(negedge clk); req = 1'b1;
    @(negedge clk);
    @(negedge clk); req = 1'b0;
    @(posedge clk);
    edges = 0;
    while (edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ack0) break;
    end
    check({nm, " ack_edges"}, edges, 131);
    check({nm, " ack_par"}, ack1, 1'b1);
  endtask

  task automatic check_out(input string nm);
    for (int k = 0; k < 64; k++) begin
      check($sformatf("%s dm0[%0d]", nm, 64 + k), mem0[64 + k], exp0[k]);
      check($sformatf("%s dm1[%0d]", nm, 64 + k), mem1[64 + k], exp1[k]);
    end
  endtask

  initial begin
    int bad;
    int p, t, s, pe;

    vecs[0] = '{0, 10, 10, 'h60, 'h01, 1'b1, 56'h01_02_04_08_10_20_41, 56'h81_82_84_88_90_A0_41};
    vecs[1] = '{0, 10, 10, 'h60, 'h00, 1'b1, 56'h01_02_04_08_10_20_41, 56'h81_82_84_88_90_A0_41};
    vecs[2] = '{1,  5, 10, 'h48, 'h5A, 1'b0, 56'h0, 56'h0};
    vecs[3] = '{1, 30, 26, 'h48, 'h5A, 1'b0, 56'h0, 56'h0};
    vecs[4] = '{1, 10, 10, 'h48, 'h5A, 1'b0, 56'h0, 56'h0};

    repeat (3) @(negedge clk);
    check("rst ack", ack0, 1'b0);
    check("rst we", we0, 1'b0);
    check("rst addr", addr0, 8'd0);
    check("rst wdata", wd1, 8'd0);
    init = 1'b1;

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (we0 || addr0 != 8'd0 || ack0) bad++;
    end
    check("no start without arm", bad, 0);

    foreach (vecs[v]) begin
      set_image(vecs[v].sel, vecs[v].pre_raw, vecs[v].taps, vecs[v].seed);
      compute_model(vecs[v].pre_eff, vecs[v].taps, vecs[v].seed);
      run_prog($sformatf("v%0d", v));
      check_out($sformatf("v%0d", v));
      if (vecs[v].fixed)
        for (int k = 0; k < 7; k++) begin
          check($sformatf("v%0d const0[%0d]", v, k), mem0[64 + k], vecs[v].k0[55 - 8*k -: 8]);
          check($sformatf("v%0d const1[%0d]", v, k), mem1[64 + k], vecs[v].k1[55 - 8*k -: 8]);
        end
    end

    for (int r = 0; r < 3; r++) begin
      p = $urandom_range(0, 40);
      t = $urandom_range(0, 255);
      s = $urandom_range(0, 255);
      pe = (p < 10) ? 10 : (p > 26) ? 26 : p;
      set_image(2, p, t, s);
      compute_model(pe, t, s);
      run_prog($sformatf("rnd%0d", r));
      check_out($sformatf("rnd%0d", r));
    end

    // Abort during the 40th character (RD of i=39).
    set_image(1, 10, 'h48, 'h5A);
    compute_model(10, 'h48, 'h5A);
    @(negedge clk); req = 1'b1;
    @(negedge clk);
    @(negedge clk); req = 1'b0;
    @(posedge clk);
    repeat (81) @(posedge clk);
    @(negedge clk); req = 1'b1;
    @(negedge clk);
    check("abort we", we0, 1'b0);
    check("abort ack", ack0, 1'b0);
    check("abort addr", addr0, 8'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (we0 || ack0) bad++;
    end
    check("abort quiet", bad, 0);
    check("abort last written", mem0[102], exp0[38]);
    check("abort not written", mem0[103], 8'hEE);
    run_prog("rerun");
    check_out("rerun");

    // Reset pulse in the middle of WR for i=5.
    set_image(0, 10, 'h60, 'h01);
    compute_model(10, 'h60, 'h01);
    @(negedge clk); req = 1'b1;
    @(negedge clk);
    @(negedge clk); req = 1'b0;
    @(posedge clk);
    repeat (14) @(posedge clk);
    #2;
    check("pre-reset we", we0, 1'b1);
    check("pre-reset wdata", wd0, 8'h20);
    init = 1'b0;
    #1;
    check("async we", we0, 1'b0);
    check("async addr", addr0, 8'd0);
    check("async wdata", wd0, 8'd0);
    check("async wdata par", wd1, 8'd0);
    check("async ack", ack0, 1'b0);
    @(negedge clk); init = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (we0 || addr0 != 8'd0 || ack0) bad++;
    end
    check("no start after reset", bad, 0);
    check("partial write kept", mem0[68], 8'h10);
    check("unwritten after reset", mem0[70], 8'hEE);
    run_prog("post-reset");
    check_out("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encrypt_ctrl.md
ENCRYPT_CTRL -- requirements
Module: encrypt_ctrl

Interface
REQ-001 SHALL have parameter: PARITY, 0, when 1 output bit 7 = XOR of bits 6:0; when 0 bit 7 = 0.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: init  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  1  high = hold/arm; low = run program.
REQ-005 SHALL have port: ack  output  1  program-done flag.
REQ-006 SHALL have port: dm_addr  output  8  data memory address.
REQ-007 SHALL have port: dm_we  output  1  data memory write enable, one-cycle pulse per byte.
REQ-008 SHALL have port: dm_wdata  output  8  data memory write data.
REQ-009 SHALL have port: dm_rdata  input  8  data memory read data, combinational from dm_addr in the same cycle.

Function
REQ-010 SHALL use states IDLE, LD_PRE, LD_TAP, LD_SEED, RD, WR, DONE, with a 6-bit character index i.
REQ-011 SHALL set an armed flag whenever req=1 is sampled in IDLE; IDLE->LD_PRE on the first edge sampling req=0 with armed=1; armed clears on leaving IDLE.
REQ-012 SHALL, in LD_PRE, drive dm_addr=61, capture pre = dm_rdata, clamped: <10 -> 10, >26 -> 26.
REQ-013 SHALL, in LD_TAP, drive dm_addr=62, capture taps = dm_rdata[6:0].
REQ-014 SHALL, in LD_SEED, drive dm_addr=63, capture lfsr = dm_rdata[6:0]; value 0 replaced by 1; set i=0; go to RD.
REQ-015 SHALL, in RD, capture ch = dm_rdata with dm_addr=i-pre when i>=pre, else ch=0 with dm_addr=0; go to WR.
REQ-016 SHALL, in WR, drive dm_addr=64+i, dm_we=1, dm_wdata[6:0]=(ch^lfsr)[6:0], dm_wdata[7] per REQ-001.
REQ-017 SHALL, on WR exit edge, update lfsr <= {lfsr[5:0], ^(lfsr & taps)}; i<63 -> i+1, go to RD; i=63 -> DONE.
REQ-018 SHALL hold dm_we=0 in every state except WR; dm_addr is 0 in IDLE and DONE.
REQ-019 SHALL assert ack=1 only in DONE; ack rises after the 131st edge following the start edge (3 load cycles + 64x2 char cycles).
REQ-020 SHALL stay in DONE with ack=1 while req=0; req=1 sampled -> IDLE, armed=1, ack=0.
REQ-021 SHALL abort from any non-IDLE, non-DONE state to IDLE with armed=1 when req=1 is sampled; no further writes; ack stays 0.
REQ-022 SHALL use 8-bit address arithmetic; i-pre never underflows because it is evaluated only when i>=pre.

Reset
REQ-023 SHALL, on init=0 at any time, asynchronously force state=IDLE, armed=0, ack=0, dm_we=0, dm_addr=0, dm_wdata=0, i=0, lfsr=0, taps=0, pre=0, ch=0.
REQ-024 SHALL, after init release, require req=1 then req=0 before starting; a mid-run reset discards the run, leaving partial writes in memory.

Verification
REQ-025 SHALL verify: DM[0..60]=0, DM[61]=10, DM[62]=0x60, DM[63]=0x01, req 1->0 -> DM[64..70]=01,02,04,08,10,20,41; ack high 131 edges after start.
REQ-026 SHALL verify: same setup with DM[63]=0x00 -> output identical to REQ-025 (seed forced to 1).
REQ-027 SHALL verify: DM[61]=5 then DM[61]=30 -> behaves as pre=10 and pre=26; "Mr. Watson, come here. I want to see you."-0x20 at DM[0..] with taps 0x48 and seed 0x5A -> all 64 bytes match the software model.
REQ-028 SHALL verify: req driven 1 during the 40th char cycle -> dm_we=0 from next edge, ack=0, state IDLE; re-run with req 1->0 -> full correct output.
REQ-029 SHALL verify: init=0 pulsed mid-WR -> outputs zero immediately without clock; no start until req 1->0.
REQ-030 SHALL verify: PARITY=1 with REQ-025 stimulus -> DM[64..70]=81,82,84,88,90,A0,41.
